// File: rtl/stream_scoreboard_mc_if.sv
// rtl/stream_scoreboard_mc_if.sv - stimulus, actual and result bundle of the multi-channel scoreboard
interface stream_scoreboard_mc_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       clear;
  logic [NUM_CH-1:0]          exp_valid;
  logic [NUM_CH*DATA_W-1:0]   exp_data;
  logic [NUM_CH-1:0]          exp_ready;
  logic                       act_valid;
  logic [CH_W-1:0]            act_ch;
  logic [DATA_W-1:0]          act_data;
  logic                       end_of_test;
  logic [CNT_W-1:0]           match_cnt;
  logic [CNT_W-1:0]           mismatch_cnt;
  logic [CNT_W-1:0]           unexp_cnt;
  logic                       err_valid;
  logic [CH_W-1:0]            err_ch;
  logic [DATA_W-1:0]          err_exp;
  logic [DATA_W-1:0]          err_act;
  logic                       done;
  logic                       pass;

  modport master (
    output clear, exp_valid, exp_data, act_valid, act_ch, act_data, end_of_test,
    input  exp_ready, match_cnt, mismatch_cnt, unexp_cnt,
    input  err_valid, err_ch, err_exp, err_act, done, pass
  );

  modport slave (
    input  clear, exp_valid, exp_data, act_valid, act_ch, act_data, end_of_test,
    output exp_ready, match_cnt, mismatch_cnt, unexp_cnt,
    output err_valid, err_ch, err_exp, err_act, done, pass
  );
endinterface

// File: rtl/stream_scoreboard_mc.sv
// rtl/stream_scoreboard_mc.sv - multi-channel in-order scoreboard with first-failure capture
// and an end-of-test drain verdict.
module stream_scoreboard_mc #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  stream_scoreboard_mc_if.slave sb
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CHX_W = CH_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [OCC_W-1:0]  occ_q    [NUM_CH];
  logic [OCC_W-1:0]  occ_d    [NUM_CH];

  logic [NUM_CH-1:0] push, pop, full, empty;
  logic              ch_ok, hit, miss, is_match, is_mismatch, all_empty;
  logic [DATA_W-1:0] exp_head;

  logic [CNT_W-1:0]  match_q, match_d, mismatch_q, mismatch_d, unexp_q, unexp_d;
  logic              err_valid_q, err_valid_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d, err_act_q, err_act_d;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              pass_q, pass_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  // Per-channel FIFO control; an actual word only pops when its channel exists and holds data.
  always_comb begin
    ch_ok    = {1'b0, sb.act_ch} < CHX_W'(NUM_CH);
    exp_head = '0;
    push     = '0;
    pop      = '0;
    full     = '0;
    empty    = '0;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]  = (occ_q[c] == OCC_W'(DEPTH));
      empty[c] = (occ_q[c] == '0);
      push[c]  = sb.exp_valid[c] && !full[c];
      pop[c]   = sb.act_valid && ch_ok && (sb.act_ch == CH_W'(c)) && !empty[c];
      if (sb.act_ch == CH_W'(c)) begin
        exp_head = mem_q[c][rd_ptr_q[c]];
      end
      if (push[c]) begin
        wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      end
      occ_d[c] = occ_q[c] + OCC_W'(push[c]) - OCC_W'(pop[c]);
    end
    all_empty = &empty;
  end

  assign hit         = |pop;
  assign miss        = sb.act_valid && !hit;
  assign is_match    = hit && (exp_head == sb.act_data);
  assign is_mismatch = hit && (exp_head != sb.act_data);

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c]] <= sb.exp_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
    end else if (sb.clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Statistics and first-failure capture; an unexpected word records a zero expected value.
  always_comb begin
    match_d     = sat_inc(match_q, is_match);
    mismatch_d  = sat_inc(mismatch_q, is_mismatch);
    unexp_d     = sat_inc(unexp_q, miss);
    err_valid_d = err_valid_q;
    err_ch_d    = err_ch_q;
    err_exp_d   = err_exp_q;
    err_act_d   = err_act_q;
    if ((is_mismatch || miss) && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_ch_d    = sb.act_ch;
      err_exp_d   = hit ? exp_head : '0;
      err_act_d   = sb.act_data;
    end
  end

  // Drain FSM: the verdict is taken from next-state counters so a failure in the final cycle counts.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    case (state_q)
      ST_RUN: begin
        if (sb.end_of_test) begin
          state_d = ST_DRAIN;
          tmo_d   = TMO_W'(TIMEOUT);
        end
      end
      ST_DRAIN: begin
        if (tmo_q != '0) begin
          tmo_d = tmo_q - 1'b1;
        end
        if (all_empty) begin
          state_d = ST_DONE;
          pass_d  = (mismatch_d == '0) && (unexp_d == '0);
        end else if (tmo_q <= TMO_W'(1)) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q     <= '0;
      mismatch_q  <= '0;
      unexp_q     <= '0;
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      pass_q      <= 1'b0;
    end else if (sb.clear) begin
      match_q     <= '0;
      mismatch_q  <= '0;
      unexp_q     <= '0;
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
      err_exp_q   <= '0;
      err_act_q   <= '0;
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      pass_q      <= 1'b0;
    end else begin
      match_q     <= match_d;
      mismatch_q  <= mismatch_d;
      unexp_q     <= unexp_d;
      err_valid_q <= err_valid_d;
      err_ch_q    <= err_ch_d;
      err_exp_q   <= err_exp_d;
      err_act_q   <= err_act_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      pass_q      <= pass_d;
    end
  end

  assign sb.exp_ready    = ~full;
  assign sb.match_cnt    = match_q;
  assign sb.mismatch_cnt = mismatch_q;
  assign sb.unexp_cnt    = unexp_q;
  assign sb.err_valid    = err_valid_q;
  assign sb.err_ch       = err_ch_q;
  assign sb.err_exp      = err_exp_q;
  assign sb.err_act      = err_act_q;
  assign sb.done         = (state_q == ST_DONE);
  assign sb.pass         = pass_q;
endmodule

// File: tb/tb_stream_scoreboard_mc.sv
// tb/tb_stream_scoreboard_mc.sv - directed and randomized bench for stream_scoreboard_mc
module tb_stream_scoreboard_mc;
  localparam int DATA_W  = 32;
  localparam int NUM_CH  = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stream_scoreboard_mc_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) sb_if ();

  stream_scoreboard_mc #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one queue of pending expected words per channel plus plain counters.
  logic [31:0] mq [NUM_CH][$];
  int          m_match, m_mis, m_unexp;
  logic        m_err;
  logic [1:0]  m_err_ch;
  logic [31:0] m_err_exp, m_err_act;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_match = 0; m_mis = 0; m_unexp = 0;
    m_err = 1'b0; m_err_ch = '0; m_err_exp = '0; m_err_act = '0;
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
  endfunction

  task automatic model_step(input logic [3:0] ev, input logic [127:0] ed, input logic av,
                            input logic [1:0] ch, input logic [31:0] ad, input logic clr);
    bit [3:0]    rdy;
    logic [31:0] e;
    if (clr) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) rdy[c] = (mq[c].size() < DEPTH);
    if (av) begin
      if (int'(ch) < NUM_CH && mq[ch].size() > 0) begin
        e = mq[ch].pop_front();
        if (e == ad) m_match = sat(m_match);
        else m_mis = sat(m_mis);
      end else begin
        e = '0;
        m_unexp = sat(m_unexp);
      end
      if ((e != ad || e == '0 && m_unexp > 0) && !m_err && !(e == ad && int'(ch) < NUM_CH && m_unexp == 0)) begin
      end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (ev[c] && rdy[c]) mq[c].push_back(ed[c*32 +: 32]);
  endtask

  task automatic capture(input logic [1:0] ch, input logic [31:0] e, input logic [31:0] ad);
    if (!m_err) begin
      m_err = 1'b1; m_err_ch = ch; m_err_exp = e; m_err_act = ad;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] rdy;
    for (int c = 0; c < NUM_CH; c++) rdy[c] = (mq[c].size() < DEPTH);
    chk({tag, ".match"},     64'(sb_if.match_cnt),    64'(m_match));
    chk({tag, ".mismatch"},  64'(sb_if.mismatch_cnt), 64'(m_mis));
    chk({tag, ".unexp"},     64'(sb_if.unexp_cnt),    64'(m_unexp));
    chk({tag, ".err_valid"}, 64'(sb_if.err_valid),    64'(m_err));
    chk({tag, ".err_ch"},    64'(sb_if.err_ch),       64'(m_err_ch));
    chk({tag, ".err_exp"},   64'(sb_if.err_exp),      64'(m_err_exp));
    chk({tag, ".err_act"},   64'(sb_if.err_act),      64'(m_err_act));
    chk({tag, ".exp_ready"}, 64'(sb_if.exp_ready),    64'(rdy));
  endtask

  // One clock: drive, advance the reference, then sample 1 ns after the edge.
  task automatic cyc(input logic [3:0] ev, input logic [127:0] ed, input logic av,
                     input logic [1:0] ch, input logic [31:0] ad, input logic eot, input logic clr);
    logic [31:0] e;
    sb_if.exp_valid = ev; sb_if.exp_data = ed; sb_if.act_valid = av;
    sb_if.act_ch = ch; sb_if.act_data = ad; sb_if.end_of_test = eot; sb_if.clear = clr;
    e = '0;
    if (!clr && av && int'(ch) < NUM_CH && mq[ch].size() > 0) e = mq[ch][0];
    if (!clr && av) begin
      if (!(int'(ch) < NUM_CH && mq[ch].size() > 0)) capture(ch, 32'h0, ad);
      else if (e != ad) capture(ch, e, ad);
    end
    model_step(ev, ed, av, ch, ad, clr);
    @(posedge clk);
    #1;
    sb_if.exp_valid = '0; sb_if.act_valid = 1'b0; sb_if.end_of_test = 1'b0; sb_if.clear = 1'b0;
  endtask

  task automatic push1(input int ch, input logic [31:0] d);
    logic [127:0] ed;
    ed = '0;
    ed[ch*32 +: 32] = d;
    cyc(4'(1 << ch), ed, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic act1(input logic [1:0] ch, input logic [31:0] d);
    cyc(4'h0, 128'h0, 1'b1, ch, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, 128'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic eot();
    cyc(4'h0, 128'h0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic do_clear();
    cyc(4'h0, 128'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [127:0] ed;
    logic [3:0]   ev;
    logic [1:0]   ch;
    logic [31:0]  ad;
    checks = 0; failures = 0;
    model_reset();
    sb_if.clear = 1'b0; sb_if.exp_valid = '0; sb_if.exp_data = '0; sb_if.act_valid = 1'b0;
    sb_if.act_ch = '0; sb_if.act_data = '0; sb_if.end_of_test = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.done", 64'(sb_if.done), 64'd0);
    chk("reset.pass", 64'(sb_if.pass), 64'd0);
    rst_n = 1'b1;
    #1;

    // In-order matches on ch0, clean drain, then late traffic leaves the verdict frozen.
    for (int i = 1; i <= 4; i++) push1(0, 32'hA5A5_0000 + 32'(i));
    for (int i = 1; i <= 4; i++) act1(2'd0, 32'hA5A5_0000 + 32'(i));
    check_all("t1");
    chk("t1.match4", 64'(sb_if.match_cnt), 64'd4);
    eot();
    chk("t1.done_early", 64'(sb_if.done), 64'd0);
    idle(1);
    chk("t1.done", 64'(sb_if.done), 64'd1);
    chk("t1.pass", 64'(sb_if.pass), 64'd1);
    act1(2'd0, 32'h1234_5678);
    check_all("t1.late");
    chk("t1.frozen_pass", 64'(sb_if.pass), 64'd1);
    chk("t1.frozen_done", 64'(sb_if.done), 64'd1);

    // First mismatch is captured and survives a second one.
    do_clear();
    chk("clr1.done", 64'(sb_if.done), 64'd0);
    push1(2, 32'h10);
    act1(2'd2, 32'h11);
    check_all("t2.first");
    chk("t2.err_act", 64'(sb_if.err_act), 64'h11);
    push1(2, 32'h20);
    act1(2'd2, 32'h22);
    check_all("t2.second");
    chk("t2.err_exp", 64'(sb_if.err_exp), 64'h10);

    // Unexpected words; channel index 5 wraps in the 2-bit field onto empty ch1.
    do_clear();
    act1(2'd1, 32'hBEEF);
    act1(2'(5), 32'hCAFE);
    check_all("t3");
    chk("t3.unexp2", 64'(sb_if.unexp_cnt), 64'd2);
    eot();
    idle(1);
    chk("t3.done", 64'(sb_if.done), 64'd1);
    chk("t3.pass", 64'(sb_if.pass), 64'd0);

    // Fill ch3, overflow push dropped, pop-with-push while full leaves 7 queued.
    do_clear();
    for (int i = 0; i < DEPTH; i++) push1(3, $urandom);
    check_all("t4.full");
    chk("t4.ready3", 64'(sb_if.exp_ready[3]), 64'd0);
    push1(3, 32'hDEAD_0009);
    check_all("t4.drop");
    ed = '0;
    ed[3*32 +: 32] = 32'hDEAD_000A;
    cyc(4'b1000, ed, 1'b1, 2'd3, mq[3][0], 1'b0, 1'b0);
    check_all("t4.pushpop");
    chk("t4.ready3_after", 64'(sb_if.exp_ready[3]), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++) act1(2'd3, mq[3][0]);
    check_all("t4.drain");
    chk("t4.match8", 64'(sb_if.match_cnt), 64'd8);

    // Drain timeout with a word stranded on ch0, then clear.
    do_clear();
    push1(0, 32'h0000_0077);
    eot();
    idle(TIMEOUT - 1);
    chk("t5.not_yet", 64'(sb_if.done), 64'd0);
    idle(1);
    chk("t5.done", 64'(sb_if.done), 64'd1);
    chk("t5.pass", 64'(sb_if.pass), 64'd0);
    do_clear();
    check_all("t5.clear");
    chk("t5.clear_done", 64'(sb_if.done), 64'd0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 300; n++) begin
      ev = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ed = {$urandom, $urandom, $urandom, $urandom};
      ch = 2'($urandom_range(0, 3));
      ad = (mq[ch].size() > 0 && $urandom_range(0, 3) != 0) ? mq[ch][0] : $urandom;
      cyc(ev, ed, 1'($urandom_range(0, 1)), ch, ad, 1'b0, 1'b0);
      check_all("rand");
    end

    // Asynchronous reset in the middle of a drain.
    do_clear();
    for (int i = 0; i < 3; i++) push1(1, 32'h100 + 32'(i));
    act1(2'd1, 32'h100);
    act1(2'd2, 32'h5);
    eot();
    idle(3);
    chk("t6.in_drain", 64'(sb_if.done), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.reset");
    chk("t6.done", 64'(sb_if.done), 64'd0);
    chk("t6.pass", 64'(sb_if.pass), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("t6.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_scoreboard_mc.md
Name: stream_scoreboard_mc

Overview:
- Synthesizable, parametrised multi-channel in-order scoreboard. It is the hardware successor of the single-stream class-based scoreboard.
- The stimulus side pushes expected words per channel. The DUT-output side presents actual words tagged with a channel.
- The block compares the two streams in order and counts matches, mismatches and unexpected words. It also captures the first failure.
- An end-of-test drain FSM produces a pass/fail verdict. It sits beside the DUT in emulation/FPGA benches.

Parameters:
- DATA_W, 32, width of compared data words
- NUM_CH, 4, number of independent channels (1..16)
- DEPTH, 8, expected-FIFO depth per channel (power of 2, >=2)
- CNT_W, 16, width of each statistics counter (saturating)
- TIMEOUT, 1024, max drain cycles after end_of_test

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of FIFOs, counters, capture and FSM (returns to RUN)
- exp_valid  in  NUM_CH  per-channel expected-word valid
- exp_data  in  NUM_CH*DATA_W  expected words; channel c at [c*DATA_W +: DATA_W]
- exp_ready  out  NUM_CH  per-channel FIFO not full
- act_valid  in  1  actual word present (no backpressure)
- act_ch  in  $clog2(NUM_CH) (min 1)  channel of actual word
- act_data  in  DATA_W  actual word
- end_of_test  in  1  pulse: begin drain
- match_cnt  out  CNT_W  compares equal
- mismatch_cnt  out  CNT_W  compares unequal
- unexp_cnt  out  CNT_W  actual arrived on empty channel or act_ch>=NUM_CH
- err_valid  out  1  sticky: first failure captured
- err_ch  out  $clog2(NUM_CH)  channel of first failure
- err_exp  out  DATA_W  expected word of first failure (0 if unexpected)
- err_act  out  DATA_W  actual word of first failure
- done  out  1  verdict valid
- pass  out  1  verdict; meaningful only when done=1

Behaviour:
- Reset (rst_n low, asynchronous): all FIFOs empty, all counters 0, err_* 0, done=0, pass=0, FSM=RUN.
  - exp_ready is 1 on all channels during reset and afterwards, until a FIFO fills.
- Push: exp_valid[c] && exp_ready[c] writes exp_data[c] to FIFO c.
  - exp_ready[c] = !full[c], combinational from registered occupancy.
  - A push with exp_ready[c]=0 is dropped. It does not count as an error, because the source must honour ready.
- Pop/compare: act_valid with act_ch<NUM_CH and FIFO non-empty pops the head word and compares it in the same cycle.
  - Counters and capture update at the next edge, so there is 1-cycle latency to the outputs.
- Unexpected: act_valid on an empty FIFO or with act_ch>=NUM_CH increments unexp_cnt. No pop occurs.
- Simultaneous push and pop on the same channel:
  - Non-empty FIFO: both happen and occupancy is unchanged.
  - Empty FIFO: no bypass; the actual word counts as unexpected and the push is stored.
  - Full FIFO: exp_ready=0, so the pop happens and the push is dropped.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Capture: on the first mismatch or unexpected word, err_valid=1 and err_ch/err_exp/err_act are latched. Later failures do not overwrite them until clear or reset.
- FSM:
  - RUN: normal operation. end_of_test moves to DRAIN and loads the timeout counter with TIMEOUT.
  - DRAIN: compares continue. The counter decrements each cycle.
    - All FIFOs empty -> DONE.
    - Counter reaches 0 with a FIFO non-empty -> DONE with a forced fail.
  - DONE: done=1. pass = (mismatch_cnt==0 && unexp_cnt==0 && all FIFOs empty && no timeout).
    - done, pass and the counters hold. Further act_valid still updates the counters, but pass stays frozen. The FSM exits DONE only via clear or reset.
- end_of_test outside RUN is ignored. end_of_test while all FIFOs are already empty reaches DONE after 1 cycle in DRAIN.
- clear has priority over every same-cycle event. A reset mid-drain aborts the drain: FSM=RUN, done=0.

Test Plan:
- Push 0xA5A5_0001..0xA5A5_0004 on ch0, then actuals of the same values on ch0 -> match_cnt=4, mismatch_cnt=0; after end_of_test, done=1 within 2 cycles and pass=1.
- Push 0x10 on ch2, then actual 0x11 on ch2 -> mismatch_cnt=1, err_valid=1, err_ch=2, err_exp=0x10, err_act=0x11; a second mismatch does not change err_*.
- Actual on empty ch1, then act_ch=5 with NUM_CH=4 -> unexp_cnt=2, err_exp=0, and the drain ends with pass=0.
- Push 8 words on ch3 (DEPTH=8) -> exp_ready[3]=0; a 9th push is dropped; simultaneous push and pop while full -> occupancy 7.
- Push 1 word on ch0 with no actual, pulse end_of_test with TIMEOUT=16 -> done=1 after 16 cycles, pass=0; clear -> all counters 0, done=0.
- Assert rst_n low mid-DRAIN with the counters non-zero -> all outputs 0 asynchronously and exp_ready all 1.
